// File: rtl/hmac512_pkg.sv
// Shared types and helpers for the SHA-512 datapath.
// Holds the FIFO word format, error codes and padding helpers.
package hmac512_pkg;

    typedef logic [63:0] sha_word_t;

    typedef struct packed {
        sha_word_t  data;
        logic [7:0] mask;
    } sha_fifo_t;

    typedef enum logic [31:0] {
        NoError                    = 32'h0000_0000,
        SwHashStartWhenShaDisabled = 32'h0000_0002,
        SwHashStartWhenActive      = 32'h0000_0004
    } err_code_e;

    typedef enum logic [2:0] {
        PadIdle,
        PadMsg,
        Pad80,
        PadZero,
        PadLenHi,
        PadLenLo
    } pad_st_e;

    function automatic logic [3:0] popcnt8(logic [7:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, m[i]};
        end
        return c;
    endfunction

    // Mask is contiguous from the MSB, so byte n is the first free byte.
    function automatic sha_word_t pad_word(sha_word_t data, logic [7:0] mask);
        sha_word_t r;
        int        n;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (mask[7-i]) r[63-8*i -: 8] = data[63-8*i -: 8];
        end
        n = int'(popcnt8(mask));
        if (n < 8) r[63-8*n -: 8] = 8'h80;
        return r;
    endfunction

endpackage

// File: rtl/sha512_pad_seq.sv
// SHA-512 message padding sequencer.
// Passes message words through, then appends delimiter, zero fill and length.
module sha512_pad_seq
    import hmac512_pkg::*;
#(
    parameter int LenW = 128
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            sha_en_i,
    input  logic            hash_start_i,
    input  logic            hash_process_i,
    input  logic            fifo_rvalid_i,
    input  logic [71:0]     fifo_rdata_i,
    output logic            fifo_rready_o,
    output logic            shaf_rvalid_o,
    output logic [63:0]     shaf_rdata_o,
    input  logic            shaf_rready_i,
    output logic            shaf_last_o,
    output logic [LenW-1:0] msg_len_o,
    output logic            hash_done_o,
    output logic            err_valid_o,
    output logic [31:0]     err_code_o
);

    pad_st_e         st_q, st_d;
    logic [3:0]      idx_q, idx_d;
    logic [LenW-1:0] len_q, len_d;
    logic            proc_q, proc_d;
    logic            done_q, done_d;
    logic            errv_q, errv_d;
    err_code_e       errc_q, errc_d;

    sha_fifo_t  fifo_w;
    logic [3:0] idx_nx;
    logic       acc;
    logic       full;

    assign fifo_w = sha_fifo_t'(fifo_rdata_i);
    assign idx_nx = idx_q + 4'd1;
    assign acc    = shaf_rvalid_o && shaf_rready_i;
    assign full   = (fifo_w.mask == 8'hFF);

    always_comb begin
        st_d          = st_q;
        idx_d         = idx_q;
        len_d         = len_q;
        proc_d        = proc_q;
        done_d        = 1'b0;
        errv_d        = 1'b0;
        errc_d        = errc_q;
        shaf_rvalid_o = 1'b0;
        shaf_rdata_o  = '0;
        shaf_last_o   = 1'b0;
        fifo_rready_o = 1'b0;

        unique case (st_q)
            PadIdle: begin
                if (hash_start_i && sha_en_i) begin
                    st_d   = PadMsg;
                    idx_d  = '0;
                    len_d  = '0;
                    proc_d = hash_process_i;
                end
            end
            PadMsg: begin
                proc_d        = proc_q | hash_process_i;
                fifo_rready_o = shaf_rready_i;
                shaf_rvalid_o = fifo_rvalid_i;
                shaf_rdata_o  = full ? fifo_w.data
                                     : pad_word(fifo_w.data, fifo_w.mask);
                if (acc) begin
                    len_d = len_q + LenW'({popcnt8(fifo_w.mask), 3'b000});
                    idx_d = idx_nx;
                    if (!full) st_d = (idx_nx == 4'd14) ? PadLenHi : PadZero;
                end else if (!fifo_rvalid_i && proc_q) begin
                    st_d = Pad80;
                end
            end
            Pad80: begin
                shaf_rvalid_o = 1'b1;
                shaf_rdata_o  = 64'h8000_0000_0000_0000;
                if (acc) begin
                    idx_d = idx_nx;
                    st_d  = (idx_nx == 4'd14) ? PadLenHi : PadZero;
                end
            end
            PadZero: begin
                shaf_rvalid_o = 1'b1;
                if (acc) begin
                    idx_d = idx_nx;
                    if (idx_nx == 4'd14) st_d = PadLenHi;
                end
            end
            PadLenHi: begin
                shaf_rvalid_o = 1'b1;
                shaf_rdata_o  = len_q[LenW-1 -: 64];
                if (acc) begin
                    idx_d = idx_nx;
                    st_d  = PadLenLo;
                end
            end
            PadLenLo: begin
                shaf_rvalid_o = 1'b1;
                shaf_rdata_o  = len_q[63:0];
                shaf_last_o   = 1'b1;
                if (acc) begin
                    idx_d  = idx_nx;
                    st_d   = PadIdle;
                    done_d = 1'b1;
                end
            end
            default: st_d = PadIdle;
        endcase

        if (hash_start_i) begin
            if (st_q != PadIdle) begin
                errv_d = 1'b1;
                errc_d = SwHashStartWhenActive;
            end else if (!sha_en_i) begin
                errv_d = 1'b1;
                errc_d = SwHashStartWhenShaDisabled;
            end
        end

        // Disable aborts the message but keeps the length for software.
        if (!sha_en_i) begin
            shaf_rvalid_o = 1'b0;
            shaf_last_o   = 1'b0;
            fifo_rready_o = 1'b0;
            st_d          = PadIdle;
            proc_d        = 1'b0;
            idx_d         = idx_q;
            len_d         = len_q;
            done_d        = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_q   <= PadIdle;
            idx_q  <= '0;
            len_q  <= '0;
            proc_q <= 1'b0;
            done_q <= 1'b0;
            errv_q <= 1'b0;
            errc_q <= NoError;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            len_q  <= len_d;
            proc_q <= proc_d;
            done_q <= done_d;
            errv_q <= errv_d;
            errc_q <= errc_d;
        end
    end

    assign msg_len_o   = len_q;
    assign hash_done_o = done_q;
    assign err_valid_o = errv_q;
    assign err_code_o  = errc_q;

endmodule

// File: tb/tb_sha512_pad_seq.sv
// Bench for sha512_pad_seq: byte-level padding model vs. emitted word stream.
// Directed cases plus random lengths and random engine backpressure.
module tb_sha512_pad_seq;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         sha_en_i;
    logic         hash_start_i;
    logic         hash_process_i;
    logic         fifo_rvalid_i;
    logic [71:0]  fifo_rdata_i;
    logic         fifo_rready_o;
    logic         shaf_rvalid_o;
    logic [63:0]  shaf_rdata_o;
    logic         shaf_rready_i;
    logic         shaf_last_o;
    logic [127:0] msg_len_o;
    logic         hash_done_o;
    logic         err_valid_o;
    logic [31:0]  err_code_o;

    int checks = 0;
    int fails  = 0;
    int got;

    logic [7:0]  msg_q[$];
    logic [71:0] fq[$];
    logic [63:0] eq[$];

    always #5 clk_i = ~clk_i;

    sha512_pad_seq dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sha_en_i       (sha_en_i),
        .hash_start_i   (hash_start_i),
        .hash_process_i (hash_process_i),
        .fifo_rvalid_i  (fifo_rvalid_i),
        .fifo_rdata_i   (fifo_rdata_i),
        .fifo_rready_o  (fifo_rready_o),
        .shaf_rvalid_o  (shaf_rvalid_o),
        .shaf_rdata_o   (shaf_rdata_o),
        .shaf_rready_i  (shaf_rready_i),
        .shaf_last_o    (shaf_last_o),
        .msg_len_o      (msg_len_o),
        .hash_done_o    (hash_done_o),
        .err_valid_o    (err_valid_o),
        .err_code_o     (err_code_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO words from msg_q, and the expected padded stream.
    task automatic build(input bit zmask);
        int          L;
        int          n;
        logic [7:0]  pb[$];
        logic [127:0] lb;
        logic [63:0] w;
        logic [7:0]  mk;
        L = msg_q.size();
        fq.delete();
        eq.delete();
        for (int i = 0; i + 8 <= L; i += 8) begin
            w = '0;
            for (int k = 0; k < 8; k++) w = {w[55:0], msg_q[i+k]};
            fq.push_back({w, 8'hFF});
        end
        n = L % 8;
        if (n != 0) begin
            w = '0;
            for (int k = 0; k < 8; k++)
                w = {w[55:0], (k < n) ? msg_q[L-n+k] : 8'($urandom)};
            mk = 8'hFF << (8 - n);
            fq.push_back({w, mk});
        end else if (zmask) begin
            fq.push_back({32'($urandom), 32'($urandom), 8'h00});
        end
        pb = msg_q;
        pb.push_back(8'h80);
        while (pb.size() % 128 != 112) pb.push_back(8'h00);
        lb = 128'(L) << 3;
        for (int k = 15; k >= 0; k--) pb.push_back(lb[8*k +: 8]);
        for (int i = 0; i < pb.size(); i += 8) begin
            w = '0;
            for (int k = 0; k < 8; k++) w = {w[55:0], pb[i+k]};
            eq.push_back(w);
        end
    endtask

    task automatic run_msg(input bit sep, input int rdy_pct, input int es);
        int          total;
        int          budget;
        bit          done_seen;
        bit          prev_stall;
        logic [63:0] prev_data;
        int          L;
        L          = msg_q.size();
        total      = eq.size();
        budget     = total * 40 + 40;
        done_seen  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        got        = 0;
        for (int c = 0; c < budget && !done_seen; c++) begin
            @(negedge clk_i);
            hash_start_i   = (c == 0) || (c == es);
            hash_process_i = sep ? (c == 1) : (c == 0);
            fifo_rvalid_i  = (fq.size() != 0);
            fifo_rdata_i   = fifo_rvalid_i ? fq[0] : 72'h0;
            shaf_rready_i  = ($urandom_range(99) < rdy_pct);
            #1;
            if (hash_done_o) done_seen = 1'b1;
            if (es > 0 && c == es + 1) begin
                chk("err_active_valid", err_valid_o, 1'b1);
                chk("err_active_code", err_code_o, 32'd4);
            end
            if (!shaf_rready_i)
                chk("no_pop_unready", fifo_rready_o && fifo_rvalid_i, 1'b0);
            if (prev_stall) begin
                chk("stall_valid", shaf_rvalid_o, 1'b1);
                chk("stall_data", shaf_rdata_o, prev_data);
            end
            if (shaf_rvalid_o && shaf_rready_i) begin
                chk("extra_word", got < total, 1'b1);
                if (got < total) begin
                    chk("word", shaf_rdata_o, eq[got]);
                    chk("last", shaf_last_o, got == total - 1);
                end
                got++;
            end
            prev_stall = shaf_rvalid_o && !shaf_rready_i;
            prev_data  = shaf_rdata_o;
            if (fifo_rready_o && fifo_rvalid_i && fq.size() != 0)
                void'(fq.pop_front());
        end
        chk("word_count", got, total);
        chk("done_pulse", done_seen, 1'b1);
        chk("msg_len", msg_len_o, 128'(L) << 3);
        @(negedge clk_i);
        hash_start_i   = 1'b0;
        hash_process_i = 1'b0;
        fifo_rvalid_i  = 1'b0;
        shaf_rready_i  = 1'b0;
        #1;
        chk("idle_valid", shaf_rvalid_o, 1'b0);
        chk("done_once", hash_done_o, 1'b0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        sha_en_i       = 1'b1;
        hash_start_i   = 1'b0;
        hash_process_i = 1'b0;
        fifo_rvalid_i  = 1'b0;
        fifo_rdata_i   = '0;
        shaf_rready_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_rvalid", shaf_rvalid_o, 1'b0);
        chk("rst_rready", fifo_rready_o, 1'b0);
        chk("rst_last", shaf_last_o, 1'b0);
        chk("rst_len", msg_len_o, 128'd0);
        chk("rst_done", hash_done_o, 1'b0);
        chk("rst_errv", err_valid_o, 1'b0);
        chk("rst_errc", err_code_o, 32'd0);

        // "abc", process a cycle after start
        msg_q = {8'h61, 8'h62, 8'h63};
        build(1'b0);
        chk("abc_words", eq.size(), 16);
        chk("abc_lenlo", eq[15], 64'h18);
        run_msg(1'b1, 100, -1);
        build(1'b0);
        run_msg(1'b1, 40, -1);

        // empty message, start and process together
        msg_q.delete();
        build(1'b0);
        run_msg(1'b0, 100, -1);
        build(1'b1);
        run_msg(1'b0, 60, -1);

        // 112 bytes: delimiter lands at idx 14, forces an extra block
        msg_q.delete();
        for (int i = 0; i < 112; i++) msg_q.push_back(8'($urandom));
        build(1'b0);
        chk("b112_words", eq.size(), 32);
        chk("b112_lenlo", eq[31], 64'h380);
        run_msg(1'b0, 100, -1);
        build(1'b0);
        run_msg(1'b1, 50, 5);

        // partial word at idx 13 and idx 14
        msg_q.delete();
        for (int i = 0; i < 111; i++) msg_q.push_back(8'($urandom));
        build(1'b0);
        run_msg(1'b0, 70, -1);
        for (int i = 0; i < 8; i++) msg_q.push_back(8'($urandom));
        build(1'b0);
        run_msg(1'b0, 70, -1);

        for (int r = 0; r < 6; r++) begin
            msg_q.delete();
            for (int i = 0; i < int'($urandom_range(300)); i++)
                msg_q.push_back(8'($urandom));
            build(1'($urandom));
            run_msg(1'($urandom), int'($urandom_range(30, 100)), -1);
        end

        // start while disabled
        @(negedge clk_i);
        sha_en_i     = 1'b0;
        hash_start_i = 1'b1;
        @(negedge clk_i);
        sha_en_i     = 1'b1;
        hash_start_i = 1'b0;
        #1;
        chk("err_dis_valid", err_valid_o, 1'b1);
        chk("err_dis_code", err_code_o, 32'd2);
        chk("err_dis_idle", shaf_rvalid_o, 1'b0);
        @(negedge clk_i);
        hash_process_i = 1'b1;
        #1;
        chk("err_pulse_1cyc", err_valid_o, 1'b0);
        @(negedge clk_i);
        hash_process_i = 1'b0;
        #1;
        chk("proc_idle_noerr", err_valid_o, 1'b0);
        chk("proc_idle_valid", shaf_rvalid_o, 1'b0);

        // enable dropped while zero-filling
        msg_q = {8'h41};
        build(1'b0);
        got = 0;
        for (int c = 0; c < 50 && got < 3; c++) begin
            @(negedge clk_i);
            hash_start_i   = (c == 0);
            hash_process_i = (c == 0);
            fifo_rvalid_i  = (fq.size() != 0);
            fifo_rdata_i   = fifo_rvalid_i ? fq[0] : 72'h0;
            shaf_rready_i  = 1'b1;
            #1;
            if (shaf_rvalid_o && shaf_rready_i) begin
                chk("drop_word", shaf_rdata_o, eq[got]);
                got++;
            end
            if (fifo_rready_o && fifo_rvalid_i && fq.size() != 0)
                void'(fq.pop_front());
        end
        chk("drop_reach", got, 3);
        @(negedge clk_i);
        hash_start_i   = 1'b0;
        hash_process_i = 1'b0;
        fifo_rvalid_i  = 1'b0;
        shaf_rready_i  = 1'b0;
        sha_en_i       = 1'b0;
        @(negedge clk_i);
        sha_en_i      = 1'b1;
        shaf_rready_i = 1'b1;
        #1;
        chk("drop_idle", shaf_rvalid_o, 1'b0);
        chk("drop_len_hold", msg_len_o, 128'd8);
        @(negedge clk_i);
        #1;
        chk("drop_stay_idle", shaf_rvalid_o, 1'b0);
        msg_q.delete();
        build(1'b0);
        run_msg(1'b0, 100, -1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
